jace_video_gen: RTL and testbench
=================================

JACE_VIDEO_GEN -- requirements
Module: jace_video_gen

Interface
REQ-001 H_TOTAL, 800, clocks per line.
REQ-002 H_ACTIVE, 640, visible clocks per line (blank boundary).
REQ-003 HS_START / HS_END, 656 / 752, hsync low for HS_START <= hcnt < HS_END.
REQ-004 V_TOTAL, 525, lines per frame.
REQ-005 V_ACTIVE, 480, visible lines.
REQ-006 VS_START / VS_END, 490 / 492, vsync low for VS_START <= vcnt < VS_END.
REQ-007 COLS / ROWS, 32 / 24, character cells of the display window, anchored at hcnt=0, vcnt=0.
REQ-008 PIX_REP, 2, clocks per pixel (1, 2 or 4); cell width CW = 8*PIX_REP clocks, cell height 8*PIX_REP lines.
REQ-009 INT_LEN, 64, clocks int_n is held low per frame.
REQ-010 clk  in  1  pixel clock, sole clock.
REQ-011 reset  in  1  synchronous, active-high reset.
REQ-012 screen_addr  out  log2(COLS*ROWS)  screen RAM address, row*COLS+col.
REQ-013 screen_data  in  8  screen RAM data, 1-clock read latency; bit7 = inverse, bits6:0 = char code.
REQ-014 char_addr  out  10  char RAM address {code[6:0], line[2:0]}.
REQ-015 char_data  in  8  char RAM data, 1-clock read latency, MSB leftmost.
REQ-016 global_inv  in  1  inverts every visible pixel in the window.
REQ-017 contend_mode  in  1  0 = block CPU for whole window, 1 = per-cell slot.
REQ-018 cpu_vram_req  in  1  CPU addresses screen/char RAM.
REQ-019 cpu_fast  in  1  access is to the uncontended alias.
REQ-020 wait_n  out  1  CPU wait, active low.
REQ-021 int_n  out  1  frame interrupt, active low.
REQ-022 video / hsync / vsync / blank  out  1 each  aligned display outputs.

Function
REQ-023 hcnt wraps H_TOTAL-1 -> 0 and increments vcnt; vcnt wraps V_TOTAL-1 -> 0.
REQ-024 viden = hcnt < COLS*CW and vcnt < ROWS*CW.
REQ-025 Fetch pipeline per cell: phase 0 drive screen_addr; phase 1 latch screen_data, drive char_addr with line = (vcnt/PIX_REP) mod 8; phase 2 latch char_data and inverse bit into shift register.
REQ-026 Shift register shifts left once every PIX_REP clocks; video = viden_d ? (shift[7] ^ inv ^ global_inv) : 0.
REQ-027 hsync, vsync, blank, viden delayed exactly 3 clocks (FETCH_LAT) so that cell col 0 pixel 0 appears on video in the same clock blank first deasserts at line start.
REQ-028 blank = !(hcnt < H_ACTIVE and vcnt < V_ACTIVE), before delay.
REQ-029 int_n low from first clock of line VS_START (hcnt=0) for INT_LEN clocks, counted; independent of vsync width.
REQ-030 Mode 0: wait_n falls the clock after cpu_vram_req & !cpu_fast & viden; stays low until viden falls, then rises next clock.
REQ-031 Mode 1: CPU slot = cell phases 3..CW-1; wait_n low while request & !cpu_fast & viden & phase in 0..2; released next clock when phase reaches 3.
REQ-032 cpu_fast or !viden: wait_n never newly asserted; already-low wait_n follows REQ-030/031 release.
REQ-033 Outside window screen_addr holds last value; char_addr don't-care; video 0.

Reset
REQ-034 reset: hcnt=vcnt=0, shift=0, delay pipes cleared, int counter idle, wait_n=1, int_n=1, video=0, hsync=vsync=1, blank=0 after pipe refill.
REQ-035 reset mid-wait or mid-interrupt releases wait_n/int_n in the following clock; frame restarts at line 0.

Structure
REQ-036 Package jace_video_pkg holds default timing constants, FETCH_LAT=3 and the CW function.
REQ-037 One sub-module jace_video_timing (counters, sync, viden, cell phase); fetch/shift/arbiter stay in top.

Verification
REQ-038 Defaults, 2 frames: hsync low 96 clocks at hcnt 656..751 (+3), vsync low lines 490..491, frame = 420000 clocks.
REQ-039 screen cell(0,0)=0x81, char row 0 = 0xA5: first 16 video clocks = inverted 0xA5 doubled (0101 1010 bits each 2 clocks).
REQ-040 global_inv=1 with cell 0x01: video equals uninverted-inverse of REQ-039 within window, 0 outside.
REQ-041 Mode 0, cpu_vram_req at hcnt=100 line 10: wait_n low from 101 until viden drops, released at hcnt 513.
REQ-042 Mode 1, request at phase 1: wait_n low 2 clocks, high at phase 3; cpu_fast=1 request: wait_n stays 1.
REQ-043 INT_LEN=64: int_n low exactly 64 clocks from line 490 hcnt 0; reset asserted mid-pulse -> int_n=1 next clock.

Source files
------------

// File: rtl/jace_video_pkg.sv
// Shared timing defaults, pipeline latency and cell geometry helper for the
// Jupiter-Ace style character video generator.
package jace_video_pkg;

  localparam int H_TOTAL   = 800;
  localparam int H_ACTIVE  = 640;
  localparam int HS_START  = 656;
  localparam int HS_END    = 752;
  localparam int V_TOTAL   = 525;
  localparam int V_ACTIVE  = 480;
  localparam int VS_START  = 490;
  localparam int VS_END    = 492;
  localparam int COLS      = 32;
  localparam int ROWS      = 24;
  localparam int PIX_REP   = 2;
  localparam int INT_LEN   = 64;

  // Clocks between a cell's address phase and its first pixel on video.
  localparam int FETCH_LAT = 3;

  // CPU contention policy selected by contend_mode.
  typedef enum logic {
    CONTEND_WINDOW = 1'b0,
    CONTEND_SLOT   = 1'b1
  } contend_e;

  // Cell width in clocks (and cell height in lines).
  function automatic int cell_width(input int pix_rep);
    return 8 * pix_rep;
  endfunction

endpackage

// File: rtl/jace_video_timing.sv
// Raster counters, raw (undelayed) sync/blank, display-window enable and
// cell phase for the video generator.
module jace_video_timing
  import jace_video_pkg::*;
#(
  parameter int H_TOTAL_P  = H_TOTAL,
  parameter int H_ACTIVE_P = H_ACTIVE,
  parameter int HS_START_P = HS_START,
  parameter int HS_END_P   = HS_END,
  parameter int V_TOTAL_P  = V_TOTAL,
  parameter int V_ACTIVE_P = V_ACTIVE,
  parameter int VS_START_P = VS_START,
  parameter int VS_END_P   = VS_END,
  parameter int COLS_P     = COLS,
  parameter int ROWS_P     = ROWS,
  parameter int PIX_REP_P  = PIX_REP
) (
  input  logic                                         clk_i,
  input  logic                                         reset_i,
  output logic [$clog2(H_TOTAL_P)-1:0]                 hcnt_o,
  output logic [$clog2(V_TOTAL_P)-1:0]                 vcnt_o,
  output logic [$clog2(cell_width(PIX_REP_P))-1:0]     phase_o,
  output logic                                         viden_o,
  output logic                                         blank_o,
  output logic                                         hsync_o,
  output logic                                         vsync_o,
  output logic                                         vs_line_start_o
);

  localparam int CW = cell_width(PIX_REP_P);
  localparam int HW = $clog2(H_TOTAL_P);
  localparam int VW = $clog2(V_TOTAL_P);
  localparam int PW = $clog2(CW);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL_P - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE_P);
  localparam logic [HW-1:0] H_SS   = HW'(HS_START_P);
  localparam logic [HW-1:0] H_SE   = HW'(HS_END_P);
  localparam logic [HW-1:0] H_WIN  = HW'(COLS_P * CW);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL_P - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE_P);
  localparam logic [VW-1:0] V_SS   = VW'(VS_START_P);
  localparam logic [VW-1:0] V_SE   = VW'(VS_END_P);
  localparam logic [VW-1:0] V_WIN  = VW'(ROWS_P * CW);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;

  // Next raster position: pixel counter wraps at line end and steps the line.
  always_comb begin
    hcnt_d = hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
    end
  end

  // Raster position registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign hcnt_o          = hcnt_q;
  assign vcnt_o          = vcnt_q;
  assign phase_o         = hcnt_q[PW-1:0];
  assign viden_o         = (hcnt_q < H_WIN) && (vcnt_q < V_WIN);
  assign blank_o         = !((hcnt_q < H_ACT) && (vcnt_q < V_ACT));
  assign hsync_o         = !((hcnt_q >= H_SS) && (hcnt_q < H_SE));
  assign vsync_o         = !((vcnt_q >= V_SS) && (vcnt_q < V_SE));
  assign vs_line_start_o = (hcnt_q == '0) && (vcnt_q == V_SS);

endmodule

// File: rtl/jace_video_gen.sv
// Character-cell video generator: screen/char RAM fetch pipeline, pixel
// shifter, aligned sync outputs, frame interrupt and CPU wait arbitration.
//
// CPU wait: wait_n low tells the CPU its screen/char RAM access must stall;
// the access proceeds in the first clock wait_n is seen high. Fast-alias
// accesses and accesses outside the display window never start a stall.
module jace_video_gen
  import jace_video_pkg::*;
#(
  parameter int H_TOTAL_P  = H_TOTAL,
  parameter int H_ACTIVE_P = H_ACTIVE,
  parameter int HS_START_P = HS_START,
  parameter int HS_END_P   = HS_END,
  parameter int V_TOTAL_P  = V_TOTAL,
  parameter int V_ACTIVE_P = V_ACTIVE,
  parameter int VS_START_P = VS_START,
  parameter int VS_END_P   = VS_END,
  parameter int COLS_P     = COLS,
  parameter int ROWS_P     = ROWS,
  parameter int PIX_REP_P  = PIX_REP,
  parameter int INT_LEN_P  = INT_LEN
) (
  input  logic                                 clk,
  input  logic                                 reset,
  output logic [$clog2(COLS_P*ROWS_P)-1:0]     screen_addr,
  input  logic [7:0]                           screen_data,
  output logic [9:0]                           char_addr,
  input  logic [7:0]                           char_data,
  input  logic                                 global_inv,
  input  logic                                 contend_mode,
  input  logic                                 cpu_vram_req,
  input  logic                                 cpu_fast,
  output logic                                 wait_n,
  output logic                                 int_n,
  output logic                                 video,
  output logic                                 hsync,
  output logic                                 vsync,
  output logic                                 blank
);

  localparam int CW = cell_width(PIX_REP_P);
  localparam int HW = $clog2(H_TOTAL_P);
  localparam int VW = $clog2(V_TOTAL_P);
  localparam int PW = $clog2(CW);
  localparam int AW = $clog2(COLS_P * ROWS_P);
  localparam int IW = $clog2(INT_LEN_P + 1);

  localparam logic [PW-1:0] PH_LATCH = PW'(1);
  localparam logic [PW-1:0] PH_LOAD  = PW'(2);
  localparam logic [PW-1:0] PH_CPU   = PW'(3);

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [PW-1:0] phase;
  logic          viden, blank_raw, hsync_raw, vsync_raw, vs_line_start;

  jace_video_timing #(
    .H_TOTAL_P  (H_TOTAL_P),
    .H_ACTIVE_P (H_ACTIVE_P),
    .HS_START_P (HS_START_P),
    .HS_END_P   (HS_END_P),
    .V_TOTAL_P  (V_TOTAL_P),
    .V_ACTIVE_P (V_ACTIVE_P),
    .VS_START_P (VS_START_P),
    .VS_END_P   (VS_END_P),
    .COLS_P     (COLS_P),
    .ROWS_P     (ROWS_P),
    .PIX_REP_P  (PIX_REP_P)
  ) u_timing (
    .clk_i           (clk),
    .reset_i         (reset),
    .hcnt_o          (hcnt),
    .vcnt_o          (vcnt),
    .phase_o         (phase),
    .viden_o         (viden),
    .blank_o         (blank_raw),
    .hsync_o         (hsync_raw),
    .vsync_o         (vsync_raw),
    .vs_line_start_o (vs_line_start)
  );

  // ---------------------------------------------------------------- fetch
  logic [AW-1:0] addr_now, screen_addr_q;
  logic [2:0]    line;

  assign addr_now = AW'(int'(vcnt >> PW) * COLS_P + int'(hcnt >> PW));
  assign line     = 3'((int'(vcnt) / PIX_REP_P) % 8);

  // Remember the last window address so the screen RAM bus is quiet outside.
  always_ff @(posedge clk) begin
    if (reset)      screen_addr_q <= '0;
    else if (viden) screen_addr_q <= addr_now;
  end

  assign screen_addr = viden ? addr_now : screen_addr_q;
  assign char_addr   = {screen_data[6:0], line};

  logic [7:0]    shift_q, shift_d;
  logic          inv_q, inv_d, inv_pend_q, inv_pend_d;
  logic [PW-1:0] phase_rel;
  logic          shift_en;

  // Pixel boundaries fall every PIX_REP clocks counted from the load phase.
  assign phase_rel = phase - PH_LOAD;
  assign shift_en  = ((int'(phase_rel) % PIX_REP_P) == 0);

  // Capture the inverse bit with the code, then load glyph row and shift out.
  always_comb begin
    shift_d    = shift_q;
    inv_d      = inv_q;
    inv_pend_d = inv_pend_q;
    if (viden && (phase == PH_LATCH)) inv_pend_d = screen_data[7];
    if (viden && (phase == PH_LOAD)) begin
      shift_d = char_data;
      inv_d   = inv_pend_q;
    end else if (shift_en) begin
      shift_d = {shift_q[6:0], 1'b0};
    end
  end

  // Pixel shifter and cell attribute registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q    <= '0;
      inv_q      <= 1'b0;
      inv_pend_q <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      inv_q      <= inv_d;
      inv_pend_q <= inv_pend_d;
    end
  end

  // ------------------------------------------------------- aligned outputs
  logic [FETCH_LAT-1:0] hs_pipe_q, vs_pipe_q, bl_pipe_q, vid_pipe_q;

  // Delay raster flags by the fetch latency so they line up with pixels.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_pipe_q  <= '1;
      vs_pipe_q  <= '1;
      bl_pipe_q  <= '0;
      vid_pipe_q <= '0;
    end else begin
      hs_pipe_q  <= {hs_pipe_q[FETCH_LAT-2:0], hsync_raw};
      vs_pipe_q  <= {vs_pipe_q[FETCH_LAT-2:0], vsync_raw};
      bl_pipe_q  <= {bl_pipe_q[FETCH_LAT-2:0], blank_raw};
      vid_pipe_q <= {vid_pipe_q[FETCH_LAT-2:0], viden};
    end
  end

  assign hsync = hs_pipe_q[FETCH_LAT-1];
  assign vsync = vs_pipe_q[FETCH_LAT-1];
  assign blank = bl_pipe_q[FETCH_LAT-1];
  assign video = vid_pipe_q[FETCH_LAT-1] ? (shift_q[7] ^ inv_q ^ global_inv) : 1'b0;

  // ------------------------------------------------------ frame interrupt
  logic [IW-1:0] int_cnt_q, int_cnt_d;

  // Pulse starts on the first clock of the vsync line and runs INT_LEN clocks.
  always_comb begin
    int_cnt_d = int_cnt_q;
    if (vs_line_start)          int_cnt_d = IW'(INT_LEN_P - 1);
    else if (int_cnt_q != '0)   int_cnt_d = int_cnt_q - 1'b1;
  end

  // Interrupt length counter.
  always_ff @(posedge clk) begin
    if (reset) int_cnt_q <= '0;
    else       int_cnt_q <= int_cnt_d;
  end

  assign int_n = !(vs_line_start || (int_cnt_q != '0));

  // ----------------------------------------------------------- CPU wait
  contend_e mode;
  logic     new_req, slot_busy, wait_slot;
  logic     wait_win_q, wait_win_d, wait_slot_q, wait_slot_d;

  assign mode      = contend_e'(contend_mode);
  assign new_req   = cpu_vram_req && !cpu_fast && viden;
  assign slot_busy = (phase < PH_CPU);

  // Window mode stalls until the window ends; slot mode until phase 3.
  always_comb begin
    wait_win_d  = 1'b0;
    wait_slot_d = 1'b0;
    wait_slot   = 1'b0;
    if (mode == CONTEND_SLOT) begin
      wait_slot   = slot_busy && (new_req || wait_slot_q);
      wait_slot_d = wait_slot && (phase != PH_LOAD);
    end else begin
      wait_win_d  = wait_win_q ? viden : new_req;
    end
  end

  // Wait state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_win_q  <= 1'b0;
      wait_slot_q <= 1'b0;
    end else begin
      wait_win_q  <= wait_win_d;
      wait_slot_q <= wait_slot_d;
    end
  end

  assign wait_n = !(wait_win_q || wait_slot);

endmodule

// File: tb/tb_jace_video_gen.sv
// Directed bench for jace_video_gen. Horizontal timing is the default 800
// clocks per line; the frame is shortened to 36 lines (2 cell rows) so that
// sync, interrupt and frame wrap are all reached in a short run.
module tb_jace_video_gen;

  logic       clk;
  logic       reset;
  logic [5:0] screen_addr;
  logic [7:0] screen_data;
  logic [9:0] char_addr;
  logic [7:0] char_data;
  logic       global_inv, contend_mode, cpu_vram_req, cpu_fast;
  logic       wait_n, int_n, video, hsync, vsync, blank;

  int checks = 0;
  int errors = 0;
  int pos    = 0;

  logic [7:0] scr_mem [64];
  logic [7:0] chr_mem [1024];

  localparam logic [15:0] PAT_INV  = 16'h33CC;     // 0xA5 inverted, doubled
  localparam logic [31:0] PAT_L1   = 32'hCC3333CC; // line 1, global_inv on

  jace_video_gen #(
    .V_TOTAL_P  (36),
    .V_ACTIVE_P (32),
    .VS_START_P (33),
    .VS_END_P   (35),
    .ROWS_P     (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .screen_addr  (screen_addr),
    .screen_data  (screen_data),
    .char_addr    (char_addr),
    .char_data    (char_data),
    .global_inv   (global_inv),
    .contend_mode (contend_mode),
    .cpu_vram_req (cpu_vram_req),
    .cpu_fast     (cpu_fast),
    .wait_n       (wait_n),
    .int_n        (int_n),
    .video        (video),
    .hsync        (hsync),
    .vsync        (vsync),
    .blank        (blank)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM models with one clock of latency
  always @(posedge clk) begin
    screen_data <= scr_mem[screen_addr];
    char_data   <= chr_mem[char_addr];
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (pos %0d)", tag, obs, expv, pos);
    end
  endtask

  // Advance to a clock position counted from reset release; sample 1ns after the edge
  task automatic adv_to(input int target);
    repeat (target - pos) @(posedge clk);
    #1;
    pos = target;
  endtask

  initial begin
    reset = 1'b1; global_inv = 1'b0; contend_mode = 1'b0;
    cpu_vram_req = 1'b0; cpu_fast = 1'b0;
    for (int i = 0; i < 64; i++)   scr_mem[i] = 8'h00;
    for (int i = 0; i < 1024; i++) chr_mem[i] = 8'h00;
    scr_mem[0]  = 8'h81;   // row 0 col 0: inverse, code 1
    scr_mem[1]  = 8'h01;   // row 0 col 1: code 1
    chr_mem[8]  = 8'hA5;   // code 1 glyph row 0
    chr_mem[9]  = 8'h0F;   // code 1 glyph row 1

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wait_n", wait_n, 1); chk("rst_int_n", int_n, 1);
    chk("rst_video", video, 0);   chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);   chk("rst_blank", blank, 0);
    chk("rst_saddr", screen_addr, 0);
    reset = 1'b0;
    pos = 0;

    // Line 0: inverse cell 0x81 over glyph 0xA5
    adv_to(2); chk("l0_pre_video", video, 0);
    for (int i = 0; i < 16; i++) begin
      adv_to(3 + i); chk("l0_cell0", video, 16'(PAT_INV[15-i]));
    end
    adv_to(600); chk("l0_saddr_hold", screen_addr, 31);

    // Line 1: global_inv flips both cells
    adv_to(800); global_inv = 1'b1;
    for (int i = 0; i < 32; i++) begin
      adv_to(803 + i); chk("l1_ginv", video, 16'(PAT_L1[31-i]));
    end
    adv_to(1320); chk("l1_outside", video, 0);
    global_inv = 1'b0;

    // Line 2: glyph row 1 (0x0F) inverted
    adv_to(1603); chk("l2_px0", video, 1);
    adv_to(1610); chk("l2_px3", video, 1);
    adv_to(1611); chk("l2_px4", video, 0);
    adv_to(1618); chk("l2_px7", video, 0);

    // Line 3: blank and hsync edges (raw position + 3)
    adv_to(2400 + 642); chk("blank_642", blank, 0);
    adv_to(2400 + 643); chk("blank_643", blank, 1);
    adv_to(2400 + 658); chk("hs_658", hsync, 1);
    adv_to(2400 + 659); chk("hs_659", hsync, 0);
    adv_to(2400 + 754); chk("hs_754", hsync, 0);
    adv_to(2400 + 755); chk("hs_755", hsync, 1);

    // Line 10, window contention: request at hcnt 100
    adv_to(8100); cpu_vram_req = 1'b1; #1; chk("m0_100", wait_n, 1);
    adv_to(8101); chk("m0_101", wait_n, 0);
    adv_to(8511); chk("m0_511", wait_n, 0);
    adv_to(8512); chk("m0_512", wait_n, 0);
    adv_to(8513); chk("m0_513", wait_n, 1);
    cpu_vram_req = 1'b0;

    // Line 11, slot contention: one-clock request at phase 1 of cell 5
    adv_to(8800); contend_mode = 1'b1;
    adv_to(8880); chk("m1_idle", wait_n, 1);
    adv_to(8881); cpu_vram_req = 1'b1; #1; chk("m1_ph1", wait_n, 0);
    adv_to(8882); cpu_vram_req = 1'b0; #1; chk("m1_ph2", wait_n, 0);
    adv_to(8883); chk("m1_ph3", wait_n, 1);

    // Line 12: fast alias never waits
    adv_to(9696); cpu_vram_req = 1'b1; cpu_fast = 1'b1; #1; chk("fast_ph0", wait_n, 1);
    adv_to(9697); chk("fast_ph1", wait_n, 1);
    adv_to(9698); chk("fast_ph2", wait_n, 1);
    cpu_vram_req = 1'b0; cpu_fast = 1'b0; contend_mode = 1'b0;

    // Line 16: second cell row address
    adv_to(12800 + 48);  chk("saddr_r1c3", screen_addr, 35);
    adv_to(12800 + 600); chk("saddr_r1_hold", screen_addr, 63);

    // Vertical blank, vsync, interrupt
    adv_to(25600 + 3); chk("blank_l32", blank, 1);
    adv_to(26399); chk("int_pre", int_n, 1);
    adv_to(26400); chk("int_first", int_n, 0);
    adv_to(26402); chk("vs_pre", vsync, 1);
    adv_to(26403); chk("vs_first", vsync, 0);
    adv_to(26463); chk("int_last", int_n, 0);
    adv_to(26464); chk("int_end", int_n, 1);
    adv_to(28002); chk("vs_last", vsync, 0);
    adv_to(28003); chk("vs_end", vsync, 1);

    // Frame wrap after 36 * 800 clocks
    adv_to(28800 + 2); chk("wrap_blank_pre", blank, 1);
    adv_to(28800 + 3); chk("wrap_blank", blank, 0);
    chk("wrap_px0", video, 0);
    adv_to(28800 + 5); chk("wrap_px1", video, 1);

    // Reset in the middle of a window wait
    adv_to(30500); cpu_vram_req = 1'b1;
    adv_to(30501); chk("mw_wait", wait_n, 0);
    adv_to(30550); cpu_vram_req = 1'b0; reset = 1'b1;
    adv_to(30551); chk("mw_rst_wait_n", wait_n, 1);
    chk("mw_rst_video", video, 0);
    reset = 1'b0;
    pos = 0;
    adv_to(5); chk("restart_px1", video, 1);

    // Reset in the middle of the interrupt pulse
    adv_to(26410); chk("mi_int", int_n, 0);
    reset = 1'b1;
    adv_to(26411); chk("mi_rst_int_n", int_n, 1);
    chk("mi_rst_hsync", hsync, 1);
    reset = 1'b0;
    pos = 0;
    adv_to(4); chk("mi_restart_blank", blank, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
